// File: rtl/saw_glide_osc.sv
// Sawtooth phase-accumulator oscillator with hard sync and a
// shift-scaled linear glide between successive frequency targets.
module saw_glide_osc #(
    parameter int ACC_W = 24,
    parameter int SAW_W = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             LOCKED,
    input  logic             SAMPLE_EN,
    input  logic [ACC_W-1:0] FREQ,
    input  logic             FREQ_VALID,
    output logic             FREQ_READY,
    input  logic [3:0]       GLIDE,
    input  logic             SYNC,
    output logic [SAW_W-1:0] SAW,
    output logic             WRAP,
    output logic             HALF,
    output logic             GLIDING
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_GLIDE
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] tgt_q, tgt_d;
    logic [ACC_W-1:0] step_q, step_d;
    logic [3:0]       shift_q, shift_d;
    logic             wrap_q, wrap_d;
    logic             half_q, half_d;
    logic             gliding_q, gliding_d;

    logic             accept;
    logic             up;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] diff;
    logic [ACC_W-1:0] diff_sh;

    assign FREQ_READY = RESET_N & LOCKED & (state_q != S_LOAD);
    assign accept     = FREQ_VALID & FREQ_READY;
    assign sum        = {1'b0, acc_q} + {1'b0, inc_q};
    assign up         = tgt_q > inc_q;
    assign diff       = up ? (tgt_q - inc_q) : (inc_q - tgt_q);
    assign diff_sh    = diff >> shift_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        inc_d   = inc_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        shift_d = shift_q;
        wrap_d  = 1'b0;
        half_d  = 1'b0;
        if (LOCKED) begin
            if (SYNC) begin
                acc_d = '0;
            end else if (SAMPLE_EN) begin
                acc_d  = sum[ACC_W-1:0];
                wrap_d = sum[ACC_W];
                half_d = sum[ACC_W-1] & ~acc_q[ACC_W-1];
            end
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_LOAD: begin
                    if (shift_q == 4'd0) begin
                        inc_d   = tgt_q;
                        state_d = S_IDLE;
                    end else begin
                        step_d  = (diff_sh == '0) ? ACC_W'(1) : diff_sh;
                        state_d = S_GLIDE;
                    end
                end
                S_GLIDE: begin
                    if (inc_q == tgt_q) begin
                        state_d = S_IDLE;
                    end else if (SAMPLE_EN) begin
                        // Final step lands exactly on target, never past it
                        if (diff <= step_q)
                            inc_d = tgt_q;
                        else if (up)
                            inc_d = inc_q + step_q;
                        else
                            inc_d = inc_q - step_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
            if (accept) begin
                tgt_d   = FREQ;
                shift_d = GLIDE;
                inc_d   = inc_q;
                state_d = S_LOAD;
            end
        end
        gliding_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            inc_q     <= '0;
            tgt_q     <= '0;
            step_q    <= '0;
            shift_q   <= '0;
            wrap_q    <= 1'b0;
            half_q    <= 1'b0;
            gliding_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            inc_q     <= inc_d;
            tgt_q     <= tgt_d;
            step_q    <= step_d;
            shift_q   <= shift_d;
            wrap_q    <= wrap_d;
            half_q    <= half_d;
            gliding_q <= gliding_d;
        end
    end

    assign SAW     = acc_q[ACC_W-1 -: SAW_W];
    assign WRAP    = wrap_q;
    assign HALF    = half_q;
    assign GLIDING = gliding_q;

endmodule

// File: tb/tb_saw_glide_osc.sv
// Scoreboard bench for saw_glide_osc: expected SAW/WRAP/HALF/GLIDING
// are queued as each sample tick is driven and popped after the edge.
module tb_saw_glide_osc;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        LOCKED;
    logic        SAMPLE_EN;
    logic [23:0] FREQ;
    logic        FREQ_VALID;
    logic        FREQ_READY;
    logic [3:0]  GLIDE;
    logic        SYNC;
    logic [15:0] SAW;
    logic        WRAP;
    logic        HALF;
    logic        GLIDING;

    typedef struct packed {
        logic [15:0] saw;
        logic        wrap;
        logic        half;
        logic        gl;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          vecs = 0;
    int          errs = 0;
    logic [23:0] m_acc;
    logic [23:0] m_inc;
    logic [23:0] m_tgt;
    logic [23:0] m_step;

    always #5 CLK = ~CLK;

    saw_glide_osc #(.ACC_W(24), .SAW_W(16)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .LOCKED     (LOCKED),
        .SAMPLE_EN  (SAMPLE_EN),
        .FREQ       (FREQ),
        .FREQ_VALID (FREQ_VALID),
        .FREQ_READY (FREQ_READY),
        .GLIDE      (GLIDE),
        .SYNC       (SYNC),
        .SAW        (SAW),
        .WRAP       (WRAP),
        .HALF       (HALF),
        .GLIDING    (GLIDING)
    );

    task automatic step_clk();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_sample(input logic gl);
        logic [24:0] s;
        SAMPLE_EN = 1'b1;
        s = {1'b0, m_acc} + {1'b0, m_inc};
        e.saw  = s[23:8];
        e.wrap = s[24];
        e.half = s[23] & ~m_acc[23];
        e.gl   = gl;
        sb_q.push_back(e);
        m_acc = s[23:0];
    endtask

    task automatic glide_model();
        if (m_inc < m_tgt)
            m_inc = (m_tgt - m_inc <= m_step) ? m_tgt : m_inc + m_step;
        else if (m_inc > m_tgt)
            m_inc = (m_inc - m_tgt <= m_step) ? m_tgt : m_inc - m_step;
    endtask

    task automatic load_inc(input logic [23:0] f);
        SAMPLE_EN  = 1'b0;
        FREQ       = f;
        GLIDE      = 4'd0;
        FREQ_VALID = 1'b1;
        step_clk();
        FREQ_VALID = 1'b0;
        step_clk();
        m_inc = f;
    endtask

    task automatic sync_acc();
        SAMPLE_EN = 1'b0;
        SYNC      = 1'b1;
        step_clk();
        SYNC  = 1'b0;
        m_acc = '0;
    endtask

    task automatic start_glide(input logic [23:0] f, input logic [3:0] g);
        SAMPLE_EN  = 1'b0;
        FREQ       = f;
        GLIDE      = g;
        FREQ_VALID = 1'b1;
        step_clk();
        FREQ_VALID = 1'b0;
        step_clk();
        m_tgt = f;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) step_clk();
        vecs++;
        if ({SAW, WRAP, HALF, GLIDING, FREQ_READY} !== 20'h0) begin
            errs++;
            $display("FAIL reset_state got saw=%h w=%b h=%b g=%b rdy=%b want 0",
                     SAW, WRAP, HALF, GLIDING, FREQ_READY);
        end
        RESET_N = 1'b1;
        step_clk();
        vecs++;
        if (FREQ_READY !== 1'b1) begin
            errs++;
            $display("FAIL ready_after_reset got %b want 1", FREQ_READY);
        end
        m_acc = '0;
        m_inc = '0;
    endtask

    task automatic test_basic();
        int wraps = 0;
        int halves = 0;
        FREQ       = 24'h010000;
        GLIDE      = 4'd0;
        FREQ_VALID = 1'b1;
        push_sample(1'b1);
        step_clk();
        FREQ_VALID = 1'b0;
        e = sb_q.pop_front();
        vecs++;
        if ({SAW, WRAP, HALF, GLIDING, FREQ_READY} !== {e, 1'b0}) begin
            errs++;
            $display("FAIL basic_load got saw=%h w=%b h=%b g=%b rdy=%b want %h %b %b %b 0",
                     SAW, WRAP, HALF, GLIDING, FREQ_READY, e.saw, e.wrap, e.half, e.gl);
        end
        push_sample(1'b0);
        step_clk();
        m_inc = 24'h010000;
        e = sb_q.pop_front();
        vecs++;
        if ({SAW, WRAP, HALF, GLIDING} !== e) begin
            errs++;
            $display("FAIL basic_idle got saw=%h g=%b want %h %b",
                     SAW, GLIDING, e.saw, e.gl);
        end
        for (int n = 1; n <= 512; n++) begin
            push_sample(1'b0);
            step_clk();
            wraps  += int'(WRAP);
            halves += int'(HALF);
            e = sb_q.pop_front();
            vecs++;
            if ({SAW, WRAP, HALF, GLIDING} !== e) begin
                errs++;
                $display("FAIL basic n=%0d got saw=%h w=%b h=%b g=%b want %h %b %b %b",
                         n, SAW, WRAP, HALF, GLIDING, e.saw, e.wrap, e.half, e.gl);
            end
        end
        SAMPLE_EN = 1'b0;
        vecs++;
        if (wraps != 2 || halves != 2) begin
            errs++;
            $display("FAIL basic_counts got wraps=%0d halves=%0d want 2 2", wraps, halves);
        end
    endtask

    task automatic test_glide_up();
        load_inc(24'h001000);
        sync_acc();
        start_glide(24'h002000, 4'd4);
        m_step = 24'h000100;
        for (int n = 1; n <= 18; n++) begin
            push_sample(m_inc != m_tgt);
            glide_model();
            step_clk();
            e = sb_q.pop_front();
            vecs++;
            if ({SAW, WRAP, HALF, GLIDING} !== e) begin
                errs++;
                $display("FAIL glide_up n=%0d got saw=%h w=%b h=%b g=%b want %h %b %b %b",
                         n, SAW, WRAP, HALF, GLIDING, e.saw, e.wrap, e.half, e.gl);
            end
        end
        SAMPLE_EN = 1'b0;
    endtask

    task automatic test_glide_down();
        load_inc(24'h000105);
        sync_acc();
        start_glide(24'h000100, 4'd8);
        m_step = 24'h000001;
        for (int n = 1; n <= 300; n++) begin
            push_sample(m_inc != m_tgt);
            glide_model();
            step_clk();
            e = sb_q.pop_front();
            vecs++;
            if ({SAW, WRAP, HALF, GLIDING} !== e) begin
                errs++;
                $display("FAIL glide_down n=%0d got saw=%h w=%b h=%b g=%b want %h %b %b %b",
                         n, SAW, WRAP, HALF, GLIDING, e.saw, e.wrap, e.half, e.gl);
            end
        end
        SAMPLE_EN = 1'b0;
    endtask

    task automatic test_sync();
        load_inc(24'hFFFF00);
        sync_acc();
        for (int n = 0; n < 3; n++) begin
            if (n == 1) begin
                SYNC      = 1'b1;
                SAMPLE_EN = 1'b1;
                e = '0;
                sb_q.push_back(e);
                m_acc = '0;
            end else begin
                push_sample(1'b0);
            end
            step_clk();
            SYNC = 1'b0;
            e = sb_q.pop_front();
            vecs++;
            if ({SAW, WRAP, HALF, GLIDING} !== e) begin
                errs++;
                $display("FAIL sync n=%0d got saw=%h w=%b h=%b g=%b want %h %b %b %b",
                         n, SAW, WRAP, HALF, GLIDING, e.saw, e.wrap, e.half, e.gl);
            end
        end
        SAMPLE_EN = 1'b0;
    endtask

    task automatic test_max_inc();
        int wraps = 0;
        load_inc(24'hFFFFFF);
        sync_acc();
        for (int n = 1; n <= 16; n++) begin
            if (n == 9) load_inc(24'h000000);
            push_sample(1'b0);
            step_clk();
            wraps += int'(WRAP);
            e = sb_q.pop_front();
            vecs++;
            if ({SAW, WRAP, HALF, GLIDING} !== e) begin
                errs++;
                $display("FAIL max_inc n=%0d got saw=%h w=%b h=%b g=%b want %h %b %b %b",
                         n, SAW, WRAP, HALF, GLIDING, e.saw, e.wrap, e.half, e.gl);
            end
        end
        SAMPLE_EN = 1'b0;
        vecs++;
        if (wraps != 7) begin
            errs++;
            $display("FAIL max_inc_wraps got %0d want 7", wraps);
        end
    endtask

    task automatic test_lock();
        logic [15:0] held;
        load_inc(24'h001000);
        sync_acc();
        start_glide(24'h002000, 4'd4);
        m_step = 24'h000100;
        for (int n = 1; n <= 20; n++) begin
            if (n == 5) begin
                held       = m_acc[23:8];
                LOCKED     = 1'b0;
                FREQ       = 24'hABCDEF;
                GLIDE      = 4'd0;
                FREQ_VALID = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    SAMPLE_EN = i[0];
                    SYNC      = (i == 3);
                    step_clk();
                    vecs++;
                    if ({SAW, WRAP, HALF, GLIDING, FREQ_READY} !== {held, 4'b0010}) begin
                        errs++;
                        $display("FAIL lock_hold i=%0d got saw=%h w=%b h=%b g=%b rdy=%b want %h 0 0 1 0",
                                 i, SAW, WRAP, HALF, GLIDING, FREQ_READY, held);
                    end
                end
                SYNC       = 1'b0;
                FREQ_VALID = 1'b0;
                LOCKED     = 1'b1;
            end
            push_sample(m_inc != m_tgt);
            glide_model();
            step_clk();
            e = sb_q.pop_front();
            vecs++;
            if ({SAW, WRAP, HALF, GLIDING} !== e) begin
                errs++;
                $display("FAIL lock_resume n=%0d got saw=%h w=%b h=%b g=%b want %h %b %b %b",
                         n, SAW, WRAP, HALF, GLIDING, e.saw, e.wrap, e.half, e.gl);
            end
        end
        SAMPLE_EN = 1'b0;
    endtask

    task automatic test_reset_mid_glide();
        load_inc(24'h001000);
        sync_acc();
        start_glide(24'h002000, 4'd4);
        m_step = 24'h000100;
        for (int n = 1; n <= 3; n++) begin
            push_sample(m_inc != m_tgt);
            glide_model();
            step_clk();
            e = sb_q.pop_front();
            vecs++;
            if ({SAW, WRAP, HALF, GLIDING} !== e) begin
                errs++;
                $display("FAIL pre_reset n=%0d got saw=%h g=%b want %h %b",
                         n, SAW, GLIDING, e.saw, e.gl);
            end
        end
        SAMPLE_EN = 1'b0;
        @(posedge CLK);
        #3;
        RESET_N = 1'b0;
        #1;
        vecs++;
        if ({SAW, WRAP, HALF, GLIDING, FREQ_READY} !== 20'h0) begin
            errs++;
            $display("FAIL async_reset got saw=%h w=%b h=%b g=%b rdy=%b want 0",
                     SAW, WRAP, HALF, GLIDING, FREQ_READY);
        end
        step_clk();
        step_clk();
        RESET_N = 1'b1;
        m_acc = '0;
        m_inc = '0;
        step_clk();
        vecs++;
        if ({FREQ_READY, GLIDING} !== 2'b10) begin
            errs++;
            $display("FAIL post_reset got rdy=%b g=%b want 1 0", FREQ_READY, GLIDING);
        end
        for (int n = 1; n <= 6; n++) begin
            push_sample(1'b0);
            step_clk();
            e = sb_q.pop_front();
            vecs++;
            if ({SAW, WRAP, HALF, GLIDING} !== e) begin
                errs++;
                $display("FAIL post_reset_inc n=%0d got saw=%h w=%b h=%b g=%b want %h %b %b %b",
                         n, SAW, WRAP, HALF, GLIDING, e.saw, e.wrap, e.half, e.gl);
            end
        end
        SAMPLE_EN = 1'b0;
    endtask

    initial begin
        RESET_N    = 1'b0;
        LOCKED     = 1'b1;
        SAMPLE_EN  = 1'b0;
        FREQ       = '0;
        FREQ_VALID = 1'b0;
        GLIDE      = '0;
        SYNC       = 1'b0;
        m_acc      = '0;
        m_inc      = '0;
        m_tgt      = '0;
        m_step     = '0;
        test_reset();
        test_basic();
        test_glide_up();
        test_glide_down();
        test_sync();
        test_max_inc();
        test_lock();
        test_reset_mid_glide();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
